tour_cmd_seq: RTL and testbench
===============================

Name: tour_cmd_seq

Overview:
- Sequences the pre-computed knight's tour into motion commands for cmd_proc.
- Muxes between UART-sourced commands (idle) and tour-generated commands (tour active).
- Sits between TourLogic (move memory), UART_wrapper (cmd_UART) and cmd_proc in KnightsTour.
- Each knight move is issued as two legs: a vertical leg first, then a horizontal leg with fanfare.

Parameters:
NUM_MOVES, 24, number of moves in the tour; mv_indx runs 0..NUM_MOVES-1
POS_ACK, 8'hA5, response returned when the tour completes or in UART mode
INT_ACK, 8'h5A, response returned after each intermediate leg

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start_tour  in  1  one-cycle pulse from cmd_proc: solution ready, begin tour
move  in  8  one-hot move for the current mv_indx, from TourLogic
mv_indx  out  5  index of the move being executed
cmd_UART  in  16  command from UART_wrapper
cmd_rdy_UART  in  1  UART command valid
clr_cmd_rdy_UART  out  1  acknowledge to UART_wrapper
cmd  out  16  command to cmd_proc
cmd_rdy  out  1  command valid to cmd_proc
clr_cmd_rdy  in  1  cmd_proc has consumed cmd
send_resp  in  1  cmd_proc has finished executing cmd
resp  out  8  response byte to UART_wrapper

Behaviour:
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares. Opcodes: MOVE=4'h2, MOVE_FANFARE=4'h3.
- Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- Move decode (dx,dy):
  - bit0 (+1,+2); bit1 (-1,+2); bit2 (-2,+1); bit3 (-2,-1)
  - bit4 (-1,-2); bit5 (+1,-2); bit6 (+2,-1); bit7 (+2,+1)
- Vertical leg: {MOVE, dy>0 ? N : S, |dy|}.
- Horizontal leg: {MOVE_FANFARE, dx>0 ? E : W, |dx|}.
- States: IDLE, VERT, VERT_WAIT, HORZ, HORZ_WAIT.
- IDLE:
  - Pass-through: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=POS_ACK.
  - start_tour -> VERT, mv_indx<=0.
- VERT:
  - cmd=vertical leg, cmd_rdy=1.
  - On clr_cmd_rdy -> VERT_WAIT; cmd_rdy drops the following cycle.
- VERT_WAIT:
  - cmd_rdy=0; on send_resp -> HORZ.
- HORZ:
  - cmd=horizontal leg, cmd_rdy=1.
  - On clr_cmd_rdy -> HORZ_WAIT.
- HORZ_WAIT, on send_resp:
  - If mv_indx==NUM_MOVES-1 -> IDLE.
  - Else mv_indx<=mv_indx+1 and -> VERT.
- resp in tour states:
  - INT_ACK, except POS_ACK in HORZ_WAIT when mv_indx==NUM_MOVES-1.
  - resp is combinational from state and mv_indx, so it is valid in the cycle send_resp is high.
- Tour mode:
  - clr_cmd_rdy_UART=0 and cmd_rdy_UART is ignored; any pending UART command waits until IDLE.
- Latency: start_tour at cycle N gives cmd_rdy=1 with the leg-0 vertical command at cycle N+1.
- move is sampled combinationally in VERT/HORZ and must be stable while mv_indx is stable.
- Invalid move (zero or multi-hot) in VERT or HORZ -> IDLE next cycle, mv_indx<=0, no cmd_rdy issued.
- start_tour outside IDLE is ignored.
- send_resp outside a *_WAIT state is ignored in tour mode.
- clr_cmd_rdy and send_resp in the same cycle while in VERT: take only clr_cmd_rdy -> VERT_WAIT; the send_resp pulse is not counted. Same rule in HORZ.
- Reset (synchronous, any state):
  - State -> IDLE, mv_indx=0.
  - Registered outputs clear. cmd_rdy then follows cmd_rdy_UART, and clr_cmd_rdy_UART follows clr_cmd_rdy.
  - Reset mid-tour abandons the tour; no response is issued.
- mv_indx never exceeds NUM_MOVES-1 and has no wrap-around.

Test Plan:
- UART pass-through: rst, then cmd_UART=16'h2004, cmd_rdy_UART=1 -> cmd=16'h2004 and cmd_rdy=1 in the same cycle. Pulse clr_cmd_rdy -> clr_cmd_rdy_UART=1 in the same cycle; resp=8'hA5.
- Single move: start_tour with move=8'h01 -> cmd=16'h2002 (N, 2 squares), cmd_rdy=1 at N+1. After clr_cmd_rdy and send_resp -> cmd=16'h3BF1 (E, 1 square, fanfare); resp=8'h5A on its send_resp.
- Full tour: NUM_MOVES=24 with move cycling through 8'h01..8'h80 and auto-ack -> 48 legs issued, mv_indx stops at 23, final resp=8'hA5, state returns to IDLE.
- South/West decode: move=8'h08 -> vertical cmd 16'h27F1, horizontal cmd 16'h33F2. move=8'h40 -> 16'h27F1 then 16'h3BF2.
- Boundaries:
  - move=8'h00 or 8'h03 in VERT -> IDLE, cmd_rdy never asserted for that leg.
  - start_tour while in HORZ_WAIT -> mv_indx unchanged.
  - cmd_rdy_UART=1 during the tour -> clr_cmd_rdy_UART stays 0.
- Reset mid-tour: assert rst in HORZ_WAIT at mv_indx=5 -> next cycle IDLE, mv_indx=0, resp=8'hA5. A following start_tour restarts at index 0.

Source files
------------

// File: rtl/tour_cmd_seq_if.sv
// Signal bundle between tour_cmd_seq and its neighbours (TourLogic, UART_wrapper, cmd_proc).
// The slave modport is the sequencer's view; master is the surrounding environment.
interface tour_cmd_seq_if;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport slave (
    input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );

  modport master (
    output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );
endinterface

// File: rtl/tour_cmd_seq.sv
// Turns each knight move of a precomputed tour into a vertical and a horizontal
// motion command for cmd_proc; passes UART commands straight through when idle.
module tour_cmd_seq #(
  parameter int         NUM_MOVES = 24,
  parameter logic [7:0] POS_ACK   = 8'hA5,
  parameter logic [7:0] INT_ACK   = 8'h5A
) (
  input logic          clk,
  input logic          rst,
  tour_cmd_seq_if.slave bus
);

  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_FANFARE = 4'h3;
  localparam logic [7:0] HDG_N      = 8'h00;
  localparam logic [7:0] HDG_W      = 8'h3F;
  localparam logic [7:0] HDG_S      = 8'h7F;
  localparam logic [7:0] HDG_E      = 8'hBF;
  localparam logic [4:0] LAST_IDX   = 5'(NUM_MOVES - 1);

  typedef enum logic [2:0] {IDLE, VERT, VERT_WAIT, HORZ, HORZ_WAIT} state_t;

  state_t     state_q, state_d;
  logic [4:0] mv_indx_q, mv_indx_d;

  logic        mv_ok;
  logic        dx_pos, dy_pos;
  logic [3:0]  dx_mag, dy_mag;
  logic [15:0] vert_cmd, horz_cmd;
  logic        last_mv;

  // Anything other than a single hot bit is an invalid move and aborts the tour.
  always_comb begin
    mv_ok  = 1'b1;
    dx_pos = 1'b0;
    dy_pos = 1'b0;
    dx_mag = 4'd0;
    dy_mag = 4'd0;
    case (bus.move)
      8'h01:   {dx_pos, dx_mag, dy_pos, dy_mag} = {1'b1, 4'd1, 1'b1, 4'd2};
      8'h02:   {dx_pos, dx_mag, dy_pos, dy_mag} = {1'b0, 4'd1, 1'b1, 4'd2};
      8'h04:   {dx_pos, dx_mag, dy_pos, dy_mag} = {1'b0, 4'd2, 1'b1, 4'd1};
      8'h08:   {dx_pos, dx_mag, dy_pos, dy_mag} = {1'b0, 4'd2, 1'b0, 4'd1};
      8'h10:   {dx_pos, dx_mag, dy_pos, dy_mag} = {1'b0, 4'd1, 1'b0, 4'd2};
      8'h20:   {dx_pos, dx_mag, dy_pos, dy_mag} = {1'b1, 4'd1, 1'b0, 4'd2};
      8'h40:   {dx_pos, dx_mag, dy_pos, dy_mag} = {1'b1, 4'd2, 1'b0, 4'd1};
      8'h80:   {dx_pos, dx_mag, dy_pos, dy_mag} = {1'b1, 4'd2, 1'b1, 4'd1};
      default: mv_ok = 1'b0;
    endcase
  end

  assign vert_cmd = {OP_MOVE,    dy_pos ? HDG_N : HDG_S, dy_mag};
  assign horz_cmd = {OP_FANFARE, dx_pos ? HDG_E : HDG_W, dx_mag};
  assign last_mv  = (mv_indx_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    bus.cmd              = bus.cmd_UART;
    bus.cmd_rdy          = bus.cmd_rdy_UART;
    bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
    bus.resp             = POS_ACK;

    if (state_q != IDLE) begin
      bus.cmd_rdy          = 1'b0;
      bus.clr_cmd_rdy_UART = 1'b0;
      bus.resp             = INT_ACK;
    end

    case (state_q)
      IDLE: begin
        if (bus.start_tour) begin
          state_d   = VERT;
          mv_indx_d = '0;
        end
      end
      VERT: begin
        bus.cmd     = vert_cmd;
        bus.cmd_rdy = mv_ok;
        if (!mv_ok) begin
          state_d   = IDLE;
          mv_indx_d = '0;
        end else if (bus.clr_cmd_rdy) begin
          state_d = VERT_WAIT;
        end
      end
      VERT_WAIT: begin
        bus.cmd = vert_cmd;
        if (bus.send_resp) state_d = HORZ;
      end
      HORZ: begin
        bus.cmd     = horz_cmd;
        bus.cmd_rdy = mv_ok;
        if (!mv_ok) begin
          state_d   = IDLE;
          mv_indx_d = '0;
        end else if (bus.clr_cmd_rdy) begin
          state_d = HORZ_WAIT;
        end
      end
      HORZ_WAIT: begin
        bus.cmd = horz_cmd;
        if (last_mv) bus.resp = POS_ACK;
        // mv_indx parks on the final index once the tour completes.
        if (bus.send_resp) begin
          if (last_mv) begin
            state_d = IDLE;
          end else begin
            state_d   = VERT;
            mv_indx_d = mv_indx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mv_indx_q <= '0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  assign bus.mv_indx = mv_indx_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Scoreboard bench for tour_cmd_seq: expected legs/responses are queued when a
// tour is set up and compared as the sequencer issues them.
module tb_tour_cmd_seq;
  localparam int         NUM_MOVES = 24;
  localparam logic [7:0] POS_ACK   = 8'hA5;
  localparam logic [7:0] INT_ACK   = 8'h5A;
  localparam int DX[8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  localparam int DY[8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0]  tour_moves [32];
  logic [15:0] exp_cmd [$];
  logic [7:0]  exp_resp [$];

  tour_cmd_seq_if bus ();

  tour_cmd_seq #(.NUM_MOVES(NUM_MOVES), .POS_ACK(POS_ACK), .INT_ACK(INT_ACK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for TourLogic: move follows mv_indx from a table.
  always_comb bus.move = tour_moves[bus.mv_indx];

  function automatic logic [15:0] exp_leg(input logic [7:0] m, input bit horz);
    int dx, dy, mag;
    dx = 0;
    dy = 0;
    for (int b = 0; b < 8; b++) if (m[b]) begin dx = DX[b]; dy = DY[b]; end
    if (horz) begin
      mag = (dx < 0) ? -dx : dx;
      return {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'(mag)};
    end
    mag = (dy < 0) ? -dy : dy;
    return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'(mag)};
  endfunction

  task automatic push_moves(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      exp_cmd.push_back(exp_leg(tour_moves[i], 1'b0));
      exp_cmd.push_back(exp_leg(tour_moves[i], 1'b1));
      exp_resp.push_back(INT_ACK);
      exp_resp.push_back((i == NUM_MOVES - 1) ? POS_ACK : INT_ACK);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start_tour  = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cmd.delete();
    exp_resp.delete();
  endtask

  task automatic start_pulse();
    @(negedge clk);
    bus.start_tour = 1'b1;
    @(negedge clk);
    bus.start_tour = 1'b0;
  endtask

  // Acknowledges n legs like cmd_proc would; with hold set, stops in the
  // *_WAIT state of the last leg before send_resp.
  task automatic serve_legs(input int n, input bit hold);
    int waited;
    logic [15:0] ecmd;
    logic [7:0]  eresp;
    for (int l = 0; l < n; l++) begin
      waited = 0;
      #1;
      while (bus.cmd_rdy !== 1'b1 && waited < 20) begin
        @(negedge clk); #1; waited++;
      end
      checks++;
      if (bus.cmd_rdy !== 1'b1) begin
        errors++;
        $display("FAIL leg%0d_cmd_rdy: timed out, cmd_rdy=%b expected 1", l, bus.cmd_rdy);
        return;
      end
      ecmd = (exp_cmd.size() > 0) ? exp_cmd.pop_front() : 16'hxxxx;
      checks++;
      if (bus.cmd !== ecmd) begin
        errors++;
        $display("FAIL leg%0d_cmd: got %h expected %h (mv_indx=%0d)", l, bus.cmd, ecmd, bus.mv_indx);
      end
      bus.clr_cmd_rdy = 1'b1;
      #1;
      checks++;
      if (bus.clr_cmd_rdy_UART !== 1'b0) begin
        errors++;
        $display("FAIL leg%0d_clr_uart: got %b expected 0", l, bus.clr_cmd_rdy_UART);
      end
      @(negedge clk);
      bus.clr_cmd_rdy = 1'b0;
      #1;
      checks++;
      if (bus.cmd_rdy !== 1'b0) begin
        errors++;
        $display("FAIL leg%0d_rdy_drop: got %b expected 0", l, bus.cmd_rdy);
      end
      if (hold && l == n - 1) return;
      @(negedge clk);
      bus.send_resp = 1'b1;
      #1;
      eresp = (exp_resp.size() > 0) ? exp_resp.pop_front() : 8'hxx;
      checks++;
      if (bus.resp !== eresp) begin
        errors++;
        $display("FAIL leg%0d_resp: got %h expected %h", l, bus.resp, eresp);
      end
      @(negedge clk);
      bus.send_resp = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.cmd_UART     = 16'h0000;
    bus.cmd_rdy_UART = 1'b0;
    apply_reset();
    #1;
    checks++;
    if (bus.mv_indx !== 5'd0 || bus.cmd_rdy !== 1'b0 || bus.resp !== POS_ACK || bus.clr_cmd_rdy_UART !== 1'b0) begin
      errors++;
      $display("FAIL reset: mv_indx=%0d cmd_rdy=%b resp=%h clr_uart=%b expected 0/0/a5/0",
               bus.mv_indx, bus.cmd_rdy, bus.resp, bus.clr_cmd_rdy_UART);
    end
  endtask

  task automatic test_uart_passthru();
    @(negedge clk);
    bus.cmd_UART     = 16'h2004;
    bus.cmd_rdy_UART = 1'b1;
    #1;
    checks++;
    if (bus.cmd !== 16'h2004 || bus.cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL uart_cmd: cmd=%h cmd_rdy=%b expected 2004/1", bus.cmd, bus.cmd_rdy);
    end
    bus.clr_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (bus.clr_cmd_rdy_UART !== 1'b1 || bus.resp !== POS_ACK) begin
      errors++;
      $display("FAIL uart_clr: clr_uart=%b resp=%h expected 1/a5", bus.clr_cmd_rdy_UART, bus.resp);
    end
    @(negedge clk);
    bus.clr_cmd_rdy  = 1'b0;
    bus.cmd_rdy_UART = 1'b0;
    #1;
    checks++;
    if (bus.clr_cmd_rdy_UART !== 1'b0 || bus.cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL uart_release: clr_uart=%b cmd_rdy=%b expected 0/0", bus.clr_cmd_rdy_UART, bus.cmd_rdy);
    end
  endtask

  task automatic test_single_move();
    apply_reset();
    tour_moves[0] = 8'h01;
    tour_moves[1] = 8'h01;
    push_moves(1);
    start_pulse();
    #1;
    checks++;
    if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'h2002) begin
      errors++;
      $display("FAIL single_latency: cmd_rdy=%b cmd=%h expected 1/2002", bus.cmd_rdy, bus.cmd);
    end
    serve_legs(2, 1'b0);
    #1;
    checks++;
    if (bus.mv_indx !== 5'd1) begin
      errors++;
      $display("FAIL single_advance: mv_indx=%0d expected 1", bus.mv_indx);
    end
  endtask

  task automatic test_south_west();
    apply_reset();
    tour_moves[0] = 8'h08;
    tour_moves[1] = 8'h40;
    tour_moves[2] = 8'h01;
    push_moves(2);
    start_pulse();
    #1;
    checks++;
    if (bus.cmd !== 16'h27F1) begin
      errors++;
      $display("FAIL sw_first: cmd=%h expected 27f1", bus.cmd);
    end
    serve_legs(4, 1'b0);
  endtask

  task automatic test_full_tour();
    apply_reset();
    bus.cmd_UART     = 16'hFFFF;
    bus.cmd_rdy_UART = 1'b1;
    for (int i = 0; i < NUM_MOVES; i++) tour_moves[i] = 8'(1 << (i % 8));
    push_moves(NUM_MOVES);
    start_pulse();
    serve_legs(2 * NUM_MOVES, 1'b0);
    #1;
    checks++;
    if (bus.mv_indx !== 5'd23 || bus.cmd !== 16'hFFFF || bus.cmd_rdy !== 1'b1 || exp_cmd.size() != 0) begin
      errors++;
      $display("FAIL full_tour_end: mv_indx=%0d cmd=%h cmd_rdy=%b left=%0d expected 23/ffff/1/0",
               bus.mv_indx, bus.cmd, bus.cmd_rdy, exp_cmd.size());
    end
    bus.cmd_rdy_UART = 1'b0;
  endtask

  task automatic test_invalid();
    logic [7:0] bad [2];
    bad[0] = 8'h00;
    bad[1] = 8'h03;
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      bus.cmd_rdy_UART = 1'b0;
      tour_moves[0] = (k == 0) ? bad[0] : 8'h01;
      tour_moves[1] = bad[k];
      if (k == 1) push_moves(1);
      start_pulse();
      if (k == 1) serve_legs(2, 1'b0);
      #1;
      checks++;
      if (bus.cmd_rdy !== 1'b0) begin
        errors++;
        $display("FAIL invalid%0d_rdy: cmd_rdy=%b expected 0", k, bus.cmd_rdy);
      end
      @(negedge clk);
      bus.cmd_UART     = 16'h1234;
      bus.cmd_rdy_UART = 1'b1;
      #1;
      checks++;
      if (bus.cmd !== 16'h1234 || bus.cmd_rdy !== 1'b1 || bus.mv_indx !== 5'd0) begin
        errors++;
        $display("FAIL invalid%0d_idle: cmd=%h cmd_rdy=%b mv_indx=%0d expected 1234/1/0",
                 k, bus.cmd, bus.cmd_rdy, bus.mv_indx);
      end
      bus.cmd_rdy_UART = 1'b0;
    end
  endtask

  task automatic test_start_in_wait();
    logic [7:0] eresp;
    apply_reset();
    tour_moves[0] = 8'h02;
    tour_moves[1] = 8'h04;
    tour_moves[2] = 8'h10;
    push_moves(2);
    start_pulse();
    serve_legs(2, 1'b1);
    bus.cmd_rdy_UART = 1'b1;
    @(negedge clk);
    bus.start_tour  = 1'b1;
    bus.clr_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (bus.clr_cmd_rdy_UART !== 1'b0) begin
      errors++;
      $display("FAIL wait_clr_uart: got %b expected 0", bus.clr_cmd_rdy_UART);
    end
    @(negedge clk);
    bus.start_tour  = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    #1;
    checks++;
    if (bus.mv_indx !== 5'd0 || bus.cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL wait_start: mv_indx=%0d cmd_rdy=%b expected 0/0", bus.mv_indx, bus.cmd_rdy);
    end
    bus.send_resp = 1'b1;
    #1;
    eresp = (exp_resp.size() > 0) ? exp_resp.pop_front() : 8'hxx;
    checks++;
    if (bus.resp !== eresp) begin
      errors++;
      $display("FAIL wait_resp: got %h expected %h", bus.resp, eresp);
    end
    @(negedge clk);
    bus.send_resp = 1'b0;
    serve_legs(2, 1'b0);
    #1;
    checks++;
    if (bus.mv_indx !== 5'd2) begin
      errors++;
      $display("FAIL wait_resume: mv_indx=%0d expected 2", bus.mv_indx);
    end
    bus.cmd_rdy_UART = 1'b0;
  endtask

  task automatic test_reset_mid_tour();
    apply_reset();
    for (int i = 0; i < 8; i++) tour_moves[i] = 8'(8'h80 >> i);
    push_moves(6);
    start_pulse();
    serve_legs(12, 1'b1);
    #1;
    checks++;
    if (bus.mv_indx !== 5'd5) begin
      errors++;
      $display("FAIL mid_pre: mv_indx=%0d expected 5", bus.mv_indx);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cmd.delete();
    exp_resp.delete();
    #1;
    checks++;
    if (bus.mv_indx !== 5'd0 || bus.resp !== POS_ACK || bus.cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: mv_indx=%0d resp=%h cmd_rdy=%b expected 0/a5/0", bus.mv_indx, bus.resp, bus.cmd_rdy);
    end
    push_moves(1);
    start_pulse();
    #1;
    checks++;
    if (bus.mv_indx !== 5'd0 || bus.cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart: mv_indx=%0d cmd_rdy=%b expected 0/1", bus.mv_indx, bus.cmd_rdy);
    end
    serve_legs(2, 1'b0);
    #1;
    checks++;
    if (bus.mv_indx !== 5'd1) begin
      errors++;
      $display("FAIL mid_advance: mv_indx=%0d expected 1", bus.mv_indx);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tour_moves[i] = 8'h00;
    bus.start_tour   = 1'b0;
    bus.cmd_UART     = 16'h0000;
    bus.cmd_rdy_UART = 1'b0;
    bus.clr_cmd_rdy  = 1'b0;
    bus.send_resp    = 1'b0;
    test_reset();
    test_uart_passthru();
    test_single_move();
    test_south_west();
    test_full_tour();
    test_invalid();
    test_start_in_wait();
    test_reset_mid_tour();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
